// File: rtl/ld06_pkg.sv
// ld06_pkg: shared constants, state encodings and the CRC-8 byte update
// for the LD06 LiDAR packet receiver.
//   LD06_HEADER / LD06_VERLEN : first two bytes of every measurement packet
//   LD06_PKT_BYTES            : packet length including header and CRC
//   LD06_CRC_POLY             : CRC-8 polynomial (MSB first, init 0, no xorout)
package ld06_pkg;

  localparam int unsigned LD06_PKT_BYTES = 47;
  localparam logic [7:0]  LD06_HEADER    = 8'h54;
  localparam logic [7:0]  LD06_VERLEN    = 8'h2C;
  localparam logic [7:0]  LD06_CRC_POLY  = 8'h4D;

  typedef enum logic [1:0] {DF_IDLE, DF_DATA, DF_STOP} df_state_e;
  typedef enum logic [1:0] {PKT_HUNT, PKT_VERLEN, PKT_BODY} pkt_state_e;

  // One byte through the CRC, MSB first.
  function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    c = crc ^ data;
    for (int unsigned i = 0; i < 8; i++) begin
      c = c[7] ? ({c[6:0], 1'b0} ^ LD06_CRC_POLY) : {c[6:0], 1'b0};
    end
    return c;
  endfunction

endpackage

// File: rtl/uart_byte_deframer.sv
// uart_byte_deframer: 8N1 LSB-first deframer driven by one sampled bit per
// bit period.
//   clk, reset   : rising-edge clock, synchronous active-high reset
//   bit_in       : sampled serial bit
//   bit_valid    : one-cycle pulse when bit_in holds a new bit
//   byte_out     : last assembled byte (stable until the next byte completes)
//   byte_strobe  : one-cycle pulse, clk after a good stop bit
//   frame_err    : one-cycle pulse, clk after a bad (0) stop bit
module uart_byte_deframer
  import ld06_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       bit_in,
  input  logic       bit_valid,
  output logic [7:0] byte_out,
  output logic       byte_strobe,
  output logic       frame_err
);

  df_state_e  state_q, state_d;
  logic [2:0] bitcnt_q, bitcnt_d;
  logic [7:0] shreg_q, shreg_d;
  logic       strobe_q, strobe_d;
  logic       ferr_q, ferr_d;

  always_comb begin
    state_d  = state_q;
    bitcnt_d = bitcnt_q;
    shreg_d  = shreg_q;
    strobe_d = 1'b0;
    ferr_d   = 1'b0;
    if (bit_valid) begin
      case (state_q)
        DF_IDLE: begin
          if (!bit_in) begin
            state_d  = DF_DATA;
            bitcnt_d = '0;
          end
        end
        DF_DATA: begin
          shreg_d[bitcnt_q] = bit_in;
          bitcnt_d          = bitcnt_q + 3'd1;
          if (bitcnt_q == 3'd7) state_d = DF_STOP;
        end
        DF_STOP: begin
          state_d = DF_IDLE;
          if (bit_in) strobe_d = 1'b1;
          else        ferr_d   = 1'b1;
        end
        default: state_d = DF_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= DF_IDLE;
      bitcnt_q <= '0;
      shreg_q  <= '0;
      strobe_q <= 1'b0;
      ferr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      bitcnt_q <= bitcnt_d;
      shreg_q  <= shreg_d;
      strobe_q <= strobe_d;
      ferr_q   <= ferr_d;
    end
  end

  assign byte_out    = shreg_q;
  assign byte_strobe = strobe_q;
  assign frame_err   = ferr_q;

endmodule

// File: rtl/ld06_packet_rx.sv
// ld06_packet_rx: header-aligned, CRC-checked capture of 47-byte LD06
// measurement packets from the sampled serial bit stream.
//   clk, reset   : rising-edge clock, synchronous active-high reset
//   bit_in       : sampled serial bit from the oversampler flip-flop
//   bit_valid    : one-cycle pulse per bit period
//   packet_data  : last completed packet, byte 0 at the MSBs, CRC at [7:0]
//   packet_valid : one-cycle pulse when packet_data updates
//   crc_ok       : CRC verdict for the current packet_data
//   frame_err    : one-cycle pulse on a stop-bit error
module ld06_packet_rx
  import ld06_pkg::*;
#(
  parameter int unsigned PKT_BYTES = LD06_PKT_BYTES,
  parameter logic [7:0]  HEADER    = LD06_HEADER,
  parameter logic [7:0]  VERLEN    = LD06_VERLEN
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   bit_in,
  input  logic                   bit_valid,
  output logic [PKT_BYTES*8-1:0] packet_data,
  output logic                   packet_valid,
  output logic                   crc_ok,
  output logic                   frame_err
);

  localparam int unsigned W        = PKT_BYTES * 8;
  localparam int unsigned SW       = $clog2(W);
  localparam logic [5:0]  LAST_IDX = 6'(PKT_BYTES - 1);

  logic [7:0] rx_byte;
  logic       rx_strobe;
  logic       rx_ferr;

  uart_byte_deframer u_deframer (
    .clk        (clk),
    .reset      (reset),
    .bit_in     (bit_in),
    .bit_valid  (bit_valid),
    .byte_out   (rx_byte),
    .byte_strobe(rx_strobe),
    .frame_err  (rx_ferr)
  );

  pkt_state_e    state_q, state_d;
  logic [5:0]    idx_q, idx_d;
  logic [7:0]    crc_q, crc_d;
  logic [W-1:0]  asm_q, asm_d;
  logic [W-1:0]  pdata_q, pdata_d;
  logic          valid_q, valid_d;
  logic          crc_ok_q, crc_ok_d;
  logic [SW-1:0] slot;

  // Bit offset of the byte at idx_q inside the assembly buffer.
  assign slot = SW'(W - 8) - SW'({idx_q, 3'b000});

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    crc_d    = crc_q;
    asm_d    = asm_q;
    pdata_d  = pdata_q;
    valid_d  = 1'b0;
    crc_ok_d = crc_ok_q;
    if (rx_ferr) begin
      state_d = PKT_HUNT;
      idx_d   = '0;
    end else if (rx_strobe) begin
      case (state_q)
        PKT_HUNT: begin
          if (rx_byte == HEADER) begin
            asm_d[W-1 -: 8] = rx_byte;
            crc_d           = crc8_byte('0, rx_byte);
            idx_d           = 6'd1;
            state_d         = PKT_VERLEN;
          end
        end
        PKT_VERLEN: begin
          if (rx_byte == VERLEN) begin
            asm_d[W-9 -: 8] = rx_byte;
            crc_d           = crc8_byte(crc_q, rx_byte);
            idx_d           = 6'd2;
            state_d         = PKT_BODY;
          end else if (rx_byte == HEADER) begin
            // A repeated header re-anchors the packet on the newer byte.
            asm_d[W-1 -: 8] = rx_byte;
            crc_d           = crc8_byte('0, rx_byte);
            idx_d           = 6'd1;
          end else begin
            state_d = PKT_HUNT;
            idx_d   = '0;
          end
        end
        PKT_BODY: begin
          asm_d[slot +: 8] = rx_byte;
          if (idx_q == LAST_IDX) begin
            pdata_d  = asm_d;
            crc_ok_d = (crc_q == rx_byte);
            valid_d  = 1'b1;
            state_d  = PKT_HUNT;
            idx_d    = '0;
          end else begin
            crc_d = crc8_byte(crc_q, rx_byte);
            idx_d = idx_q + 6'd1;
          end
        end
        default: begin
          state_d = PKT_HUNT;
          idx_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= PKT_HUNT;
      idx_q    <= '0;
      crc_q    <= '0;
      asm_q    <= '0;
      pdata_q  <= '0;
      valid_q  <= 1'b0;
      crc_ok_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      crc_q    <= crc_d;
      asm_q    <= asm_d;
      pdata_q  <= pdata_d;
      valid_q  <= valid_d;
      crc_ok_q <= crc_ok_d;
    end
  end

  assign packet_data  = pdata_q;
  assign packet_valid = valid_q;
  assign crc_ok       = crc_ok_q;
  assign frame_err    = rx_ferr;

endmodule
